// File: rtl/mef_pkg.sv
// mef_pkg: shared state codes, actuator states and counter width helpers
// for the mef_actuator_ctrl slice.
package mef_pkg;

  // FSM state codes produced by the upstream irrigation/tank controller
  typedef enum logic [1:0] {
    VZ   = 2'b00,
    EN   = 2'b01,
    ERRO = 2'b10,
    REGA = 2'b11
  } state_code_t;

  // Per-actuator drive state
  typedef enum logic {
    ACT_OFF = 1'b0,
    ACT_ON  = 1'b1
  } act_state_t;

  // Bits needed to hold values 0..max_val (never less than one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Dwell counter width: large enough to saturate at the longer dwell
  function automatic int unsigned dwell_width(input int unsigned on_cyc,
                                              input int unsigned off_cyc);
    return cnt_width((on_cyc > off_cyc) ? on_cyc : off_cyc);
  endfunction

endpackage

// File: rtl/mef_actuator_ctrl_act_dwell.sv
// act_dwell: single actuator OFF/ON state machine with a saturating dwell
// counter. The counter clears on every state change; i_force_off drops the
// actuator regardless of dwell and also blocks switch-on.
module act_dwell
  import mef_pkg::*;
#(
  parameter int unsigned MIN_ON_CYC  = 8,
  parameter int unsigned MIN_OFF_CYC = 8
) (
  input  logic clock,
  input  logic resetN,
  input  logic i_target,
  input  logic i_allow_on,
  input  logic i_force_off,
  output logic o_on
);

  localparam int unsigned         CNT_W   = dwell_width(MIN_ON_CYC, MIN_OFF_CYC);
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  act_state_t       r_state;
  act_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // State and dwell register; off-dwell preloaded saturated so the first
  // switch-on after reset is not delayed
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      r_state <= ACT_OFF;
      r_cnt   <= CNT_MAX;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: dwell-qualified transitions, force_off wins
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    case (r_state)
      ACT_OFF: begin
        if (i_target && i_allow_on && !i_force_off &&
            (r_cnt >= CNT_W'(MIN_OFF_CYC))) begin
          w_state_nxt = ACT_ON;
          w_cnt_nxt   = '0;
        end
      end
      ACT_ON: begin
        if (i_force_off || (!i_target && (r_cnt >= CNT_W'(MIN_ON_CYC)))) begin
          w_state_nxt = ACT_OFF;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ACT_OFF;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_on = (r_state == ACT_ON);

endmodule

// File: rtl/mef_actuator_ctrl.sv
// mef_actuator_ctrl: turns the controller state code into valve/pump/alarm
// drives. Settle-filters state changes (ERRO bypasses the filter), enforces
// dwell times and break-before-make between valve and pump, blinks the alarm
// in ERRO. Optional valve watchdog enabled by `define ACT_RUNTIME_LIMIT_EN.
module mef_actuator_ctrl
  import mef_pkg::*;
#(
  parameter int unsigned SETTLE_CYC     = 2,
  parameter int unsigned MIN_ON_CYC     = 8,
  parameter int unsigned MIN_OFF_CYC    = 8,
  parameter int unsigned BLINK_HALF_CYC = 4
`ifdef ACT_RUNTIME_LIMIT_EN
  ,
  parameter int unsigned MAX_FILL_CYC   = 64
`endif
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [1:0] state_in,
  output logic [1:0] applied_state,
  output logic       valve_en,
  output logic       pump_en,
  output logic       alarm,
  output logic       fill_timeout
);

  localparam int unsigned SET_W   = cnt_width(SETTLE_CYC);
  localparam int unsigned BLINK_W = cnt_width(BLINK_HALF_CYC);

  state_code_t        w_state_in;
  state_code_t        r_last;
  state_code_t        r_applied;
  state_code_t        w_applied_nxt;
  logic [SET_W-1:0]   r_stab;
  logic [SET_W-1:0]   w_stab_nxt;
  logic               w_err;
  logic               w_valve_on;
  logic               w_pump_on;
  logic               r_valve_on_d;
  logic               r_pump_on_d;
  logic               w_valve_allow;
  logic               w_pump_allow;
  logic               w_valve_force;
  logic               r_alarm;
  logic               r_err_d;
  logic [BLINK_W-1:0] r_blink_cnt;

  assign w_state_in = state_code_t'(state_in);
  assign w_err      = (r_applied == ERRO);

  // Settle filter: count consecutive identical samples, ERRO accepted at once
  always_comb begin
    w_stab_nxt    = SET_W'(1);
    w_applied_nxt = r_applied;
    if (w_state_in == r_last) begin
      if (r_stab >= SET_W'(SETTLE_CYC)) w_stab_nxt = r_stab;
      else                              w_stab_nxt = r_stab + SET_W'(1);
    end
    if (w_state_in == ERRO)                    w_applied_nxt = ERRO;
    else if (w_stab_nxt >= SET_W'(SETTLE_CYC)) w_applied_nxt = w_state_in;
  end

  // Sample register and accepted state code
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      r_last    <= VZ;
      r_stab    <= '0;
      r_applied <= VZ;
    end else begin
      r_last    <= w_state_in;
      r_stab    <= w_stab_nxt;
      r_applied <= w_applied_nxt;
    end
  end

  // One-cycle history of each drive, for the all-off gap on handover
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      r_valve_on_d <= 1'b0;
      r_pump_on_d  <= 1'b0;
    end else begin
      r_valve_on_d <= w_valve_on;
      r_pump_on_d  <= w_pump_on;
    end
  end

  assign w_valve_allow = !w_pump_on && !r_pump_on_d;
  assign w_pump_allow  = !w_valve_on && !r_valve_on_d;

`ifdef ACT_RUNTIME_LIMIT_EN
  localparam int unsigned FILL_W = cnt_width(MAX_FILL_CYC);

  logic [FILL_W-1:0] r_fill_cnt;
  logic              r_fill_timeout;
  logic              w_fill_trip;

  assign w_fill_trip = w_valve_on && (r_fill_cnt >= FILL_W'(MAX_FILL_CYC - 1));

  // Valve watchdog: count consecutive on-cycles, latch a sticky timeout
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      r_fill_cnt     <= '0;
      r_fill_timeout <= 1'b0;
    end else begin
      if (w_valve_on && !w_fill_trip) r_fill_cnt <= r_fill_cnt + FILL_W'(1);
      else                            r_fill_cnt <= '0;
      if (w_fill_trip)                r_fill_timeout <= 1'b1;
      else if (w_applied_nxt == VZ)   r_fill_timeout <= 1'b0;
    end
  end

  assign w_valve_force = w_err || w_fill_trip || r_fill_timeout;
  assign fill_timeout  = r_fill_timeout;
`else
  assign w_valve_force = w_err;
  assign fill_timeout  = 1'b0;
`endif

  act_dwell #(
    .MIN_ON_CYC  (MIN_ON_CYC),
    .MIN_OFF_CYC (MIN_OFF_CYC)
  ) u_valve (
    .clock       (clock),
    .resetN      (resetN),
    .i_target    (r_applied == EN),
    .i_allow_on  (w_valve_allow),
    .i_force_off (w_valve_force),
    .o_on        (w_valve_on)
  );

  act_dwell #(
    .MIN_ON_CYC  (MIN_ON_CYC),
    .MIN_OFF_CYC (MIN_OFF_CYC)
  ) u_pump (
    .clock       (clock),
    .resetN      (resetN),
    .i_target    (r_applied == REGA),
    .i_allow_on  (w_pump_allow),
    .i_force_off (w_err),
    .o_on        (w_pump_on)
  );

  // Alarm blinker: on at ERRO entry, toggles each half period, phase restarts
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      r_alarm     <= 1'b0;
      r_err_d     <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_err_d <= w_err;
      if (!w_err) begin
        r_alarm     <= 1'b0;
        r_blink_cnt <= '0;
      end else if (!r_err_d) begin
        r_alarm     <= 1'b1;
        r_blink_cnt <= '0;
      end else if (r_blink_cnt == BLINK_W'(BLINK_HALF_CYC - 1)) begin
        r_alarm     <= !r_alarm;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign applied_state = r_applied;
  assign valve_en      = w_valve_on;
  assign pump_en       = w_pump_on;
  assign alarm         = r_alarm;

endmodule

// File: tb/tb_mef_actuator_ctrl.sv
// tb_mef_actuator_ctrl: directed vector table, hand-written corner sequences
// and randomized state codes checked against a timestamp-based reference model.
module tb_mef_actuator_ctrl;
  import mef_pkg::*;

  localparam int SETTLE   = 2;
  localparam int MIN_ON   = 8;
  localparam int MIN_OFF  = 8;
  localparam int BLINK    = 4;
`ifdef ACT_RUNTIME_LIMIT_EN
  localparam int MAX_FILL = 64;
`endif

  logic       clock;
  logic       resetN;
  logic [1:0] state_in;
  logic [1:0] applied_state;
  logic       valve_en;
  logic       pump_en;
  logic       alarm;
  logic       fill_timeout;

  mef_actuator_ctrl dut (
    .clock         (clock),
    .resetN        (resetN),
    .state_in      (state_in),
    .applied_state (applied_state),
    .valve_en      (valve_en),
    .pump_en       (pump_en),
    .alarm         (alarm),
    .fill_timeout  (fill_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] ap;
    logic       v;
    logic       p;
    logic       a;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  // reference model: time stamps of last transitions, sample history
  logic [1:0] m_hist[$];
  int         m_n;
  logic [1:0] m_ap;
  logic [1:0] m_ap_prev;
  bit         m_v_on, m_p_on, m_alarm, m_fto;
  int         m_v_t, m_p_t, m_err_start;

  function automatic void add(input logic [1:0] st, input logic [1:0] ap,
                              input logic v, input logic p, input logic a);
    vec_t r;
    r.st = st; r.ap = ap; r.v = v; r.p = p; r.a = a;
    vecs.push_back(r);
  endfunction

  function automatic logic [5:0] dut_vec();
    return {applied_state, valve_en, pump_en, alarm, fill_timeout};
  endfunction

  function automatic logic [5:0] model_vec();
    return {m_ap, m_v_on, m_p_on, m_alarm, m_fto};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (ap,v,p,a,fto) at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_n = 0; m_ap = VZ; m_ap_prev = VZ;
    m_v_on = 0; m_p_on = 0; m_alarm = 0; m_fto = 0;
    m_v_t = -1000; m_p_t = -1000; m_err_start = 0;
  endtask

  // Advance the model by one clock edge with sample s
  task automatic model_step(input logic [1:0] s);
    int run;
    bit same, err, v_tgt, p_tgt, trip, vforce, v_nx, p_nx;
    int nv_t, np_t;
    logic [1:0] ap_pre, ap_new;
    m_n++;
    m_hist.push_back(s);
    if (m_hist.size() > SETTLE) void'(m_hist.pop_front());
    run = 0; same = 1;
    for (int i = m_hist.size() - 1; i >= 0; i--)
      if (same && m_hist[i] == s) run++; else same = 0;
    ap_pre = m_ap;
    ap_new = (s == ERRO) ? ERRO : ((run >= SETTLE) ? s : ap_pre);
    err   = (ap_pre == ERRO);
    v_tgt = (ap_pre == EN);
    p_tgt = (ap_pre == REGA);
    trip  = 0;
`ifdef ACT_RUNTIME_LIMIT_EN
    trip  = m_v_on && ((m_n - m_v_t) >= MAX_FILL);
`endif
    vforce = err || trip || m_fto;
    v_nx = m_v_on; nv_t = m_v_t;
    if (m_v_on) begin
      if (vforce || (!v_tgt && (m_n - 1 - m_v_t) >= MIN_ON)) begin v_nx = 0; nv_t = m_n; end
    end else if (v_tgt && !vforce && (m_n - 1 - m_v_t) >= MIN_OFF &&
                 !m_p_on && (m_n - m_p_t) >= 2) begin
      v_nx = 1; nv_t = m_n;
    end
    p_nx = m_p_on; np_t = m_p_t;
    if (m_p_on) begin
      if (err || (!p_tgt && (m_n - 1 - m_p_t) >= MIN_ON)) begin p_nx = 0; np_t = m_n; end
    end else if (p_tgt && !err && (m_n - 1 - m_p_t) >= MIN_OFF &&
                 !m_v_on && (m_n - m_v_t) >= 2) begin
      p_nx = 1; np_t = m_n;
    end
    if (err) begin
      if (m_ap_prev != ERRO) m_err_start = m_n;
      m_alarm = (((m_n - m_err_start) / BLINK) % 2) == 0;
    end else begin
      m_alarm = 0;
    end
    if (trip) m_fto = 1;
    else if (ap_new == VZ) m_fto = 0;
    m_ap_prev = ap_pre;
    m_ap      = ap_new;
    m_v_on = v_nx; m_v_t = nv_t;
    m_p_on = p_nx; m_p_t = np_t;
  endtask

  // One clock with the current state_in, compared against the model
  task automatic drive_cycle(input string name);
    @(posedge clock);
    model_step(state_in);
    #1;
    check(name, dut_vec(), model_vec());
    check("interlock", {5'b0, valve_en & pump_en}, 6'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    resetN = 1'b1; state_in = VZ;
    model_reset();
    repeat (3) @(posedge clock);
    #1 check("reset_state", dut_vec(), 6'b0);
    @(negedge clock);
    resetN = 1'b0;

    // Directed table: settle, glitch, handover, ERRO blink
    add(EN, VZ, 0, 0, 0);   add(EN, EN, 0, 0, 0);   add(EN, EN, 1, 0, 0);
    add(EN, EN, 1, 0, 0);   add(VZ, EN, 1, 0, 0);   add(EN, EN, 1, 0, 0);
    add(EN, EN, 1, 0, 0);   add(REGA, EN, 1, 0, 0); add(REGA, REGA, 1, 0, 0);
    add(REGA, REGA, 1, 0, 0); add(REGA, REGA, 1, 0, 0); add(REGA, REGA, 0, 0, 0);
    add(REGA, REGA, 0, 0, 0); add(REGA, REGA, 0, 1, 0); add(REGA, REGA, 0, 1, 0);
    add(ERRO, ERRO, 0, 1, 0);
    for (int k = 0; k < 20; k++) add(ERRO, ERRO, 0, 0, ((k / BLINK) % 2) == 0);

    for (int i = 0; i < vecs.size(); i++) begin
      state_in = vecs[i].st;
      @(posedge clock);
      model_step(state_in);
      #1;
      check($sformatf("table[%0d]", i), dut_vec(), {vecs[i].ap, vecs[i].v, vecs[i].p, vecs[i].a, 1'b0});
      check("interlock", {5'b0, valve_en & pump_en}, 6'b0);
    end

    // Async reset in the middle of the ERRO blink
    repeat (2) drive_cycle("erro_hold");
    @(negedge clock);
    resetN = 1'b1;
    #1 check("async_reset", dut_vec(), 6'b0);
    @(posedge clock);
    #1 check("reset_held", dut_vec(), 6'b0);
    state_in = VZ;
    @(negedge clock);
    resetN = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      drive_cycle("idle");
      check("idle_zero", dut_vec(), 6'b0);
    end

    // Long fill: watchdog trips only when the feature is built in
    state_in = EN;
    repeat (80) drive_cycle("fill");
`ifdef ACT_RUNTIME_LIMIT_EN
    check("fill_end", dut_vec(), {EN, 1'b0, 1'b0, 1'b0, 1'b1});
`else
    check("fill_end", dut_vec(), {EN, 1'b1, 1'b0, 1'b0, 1'b0});
`endif
    state_in = VZ;
    repeat (2) drive_cycle("fill_vz");
    check("fill_clear", {5'b0, fill_timeout}, 6'b0);
    state_in = EN;
    repeat (20) drive_cycle("refill");
    check("refill_open", {5'b0, valve_en}, 6'b1);

    // Randomized state codes, held for several cycles on average
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) state_in = 2'($urandom_range(3));
      drive_cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mef_actuator_ctrl.md
Name: mef_actuator_ctrl

Overview:
- Downstream stage of the irrigation/tank controller FSM: consumes its 2-bit state code and drives the physical actuators.
- Actuators: inlet valve, irrigation pump and alarm lamp.
- Filters state glitches, enforces minimum on/off dwell times and break-before-make between valve and pump, and blinks the alarm in the error state.
- Sits between the FSM output and the board I/O pins.

Parameters:
- SETTLE_CYC, 2: consecutive identical samples of state_in required before a non-error state is accepted (≥1).
- MIN_ON_CYC, 8: minimum cycles an actuator stays on once switched on.
- MIN_OFF_CYC, 8: minimum cycles an actuator stays off once switched off.
- BLINK_HALF_CYC, 4: alarm half-period in cycles.
- MAX_FILL_CYC, 64: valve-on watchdog limit; used only with ACT_RUNTIME_LIMIT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- resetN  in  1  reset, asynchronous, active-high.
- state_in  in  2  FSM state code: 00 VZ, 01 EN, 10 ERRO, 11 REGA.
- applied_state  out  2  state code currently acted upon.
- valve_en  out  1  inlet valve drive.
- pump_en  out  1  irrigation pump drive.
- alarm  out  1  alarm lamp drive.
- fill_timeout  out  1  sticky valve watchdog flag.

Behaviour:
- Reset (asynchronous, resetN=1):
  - applied_state=VZ; valve_en, pump_en, alarm, fill_timeout = 0.
  - Stability counter cleared.
  - Off-dwell counters preloaded saturated, so the first switch-on is not delayed.
- Settle filter:
  - state_in is sampled every edge.
  - A new non-ERRO code sampled at edges k..k+SETTLE_CYC-1 updates applied_state at edge k+SETTLE_CYC-1.
  - Any differing sample restarts the count.
- ERRO bypass: applied_state becomes ERRO at the first edge ERRO is sampled.
- Target mapping from applied_state:
  - EN: valve target 1, pump target 0.
  - REGA: pump target 1, valve target 0.
  - VZ: both targets 0.
  - ERRO: both targets 0, forced.
- Per-actuator FSM, states OFF and ON, each with a saturating dwell counter cleared on entry:
  - OFF→ON: target=1, off-dwell ≥ MIN_OFF_CYC, and the other actuator is OFF and was not ON in the previous cycle.
  - ON→OFF: target=0 and on-dwell ≥ MIN_ON_CYC.
- Outputs are registered: valve_en/pump_en change one edge after the enabling condition holds.
- ERRO override: the edge after applied_state becomes ERRO, both actuators go OFF regardless of dwell; dwell counters restart.
- Invariant: valve_en & pump_en never 1 in the same cycle; at least one all-off cycle separates a valve→pump or pump→valve handover.
- Alarm:
  - Goes 1 on the edge after entry to ERRO and toggles every BLINK_HALF_CYC cycles while in ERRO.
  - Goes 0 the edge after leaving ERRO; blink phase restarts on each ERRO entry.
- Leaving ERRO follows the normal settle filter.
- Simultaneous events: ERRO beats everything. A target change during an unfinished dwell is held pending until the dwell expires, then acted on if still valid.
- Reset mid-operation drops all outputs immediately, without waiting for a clock edge.

Optional Feature:
- Macro: ACT_RUNTIME_LIMIT_EN.
- Defined:
  - A valve-on counter forces the valve OFF after MAX_FILL_CYC consecutive on-cycles, ignoring MIN_ON_CYC.
  - fill_timeout is set and sticky.
  - While set, the valve is inhibited.
  - fill_timeout clears only on reset or when applied_state enters VZ.
- Undefined: no watchdog logic; fill_timeout is tied 0; MAX_FILL_CYC unused.

Decomposition:
- Package mef_pkg:
  - State code constants VZ/EN/ERRO/REGA as a 2-bit typedef.
  - Actuator OFF/ON enum.
  - Width helper for dwell counters (clog2 of max dwell + 1).
- Sub-module act_dwell: one OFF/ON dwell FSM with saturating counter and a force_off input.
  - Instantiated twice (valve, pump); interlock logic lives in the top.

Test Plan (defaults):
- Reset, then hold state_in=EN → applied_state=EN after 2 edges; valve_en=1 on the following edge; pump_en and alarm stay 0.
- From EN steady 3 cycles, switch to REGA → valve_en stays 1 until 8 on-cycles elapse, then drops; pump_en rises no earlier than the next edge after valve_en=0; both never 1 together.
- 1-cycle glitch EN→VZ→EN → applied_state stays EN, valve_en unchanged.
- state_in=ERRO while pump on for 2 cycles → applied_state=ERRO next edge; pump_en=0 and alarm=1 the edge after; alarm toggles every 4 cycles for 20 cycles.
- Assert resetN mid-ERRO blink with valve off → all outputs 0 asynchronously; after release with state_in=VZ, outputs remain 0.
- With ACT_RUNTIME_LIMIT_EN and MAX_FILL_CYC=64, hold EN 80 cycles → valve_en falls after 64 on-cycles, fill_timeout=1; apply VZ 2 cycles → fill_timeout=0; return to EN → valve re-opens after MIN_OFF_CYC.
